// File: rtl/tdnn_pkg.sv
// Shared Q1.15 constants, activation encodings, engine state encoding and
// the 16-bit saturation helper for the TDNN fully-connected engine.
package tdnn_pkg;

    localparam int FRAC_BITS = 15;
    localparam logic signed [63:0] ROUND_CONST = 64'sd16384;

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_LEAKY = 2'd1;
    localparam logic [1:0] ACT_RELU  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767)
            return 16'sh7fff;
        else if (v < -64'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/tdnn_act_unit.sv
// Combinational output stage: round the Q2.30 accumulator back to Q1.15,
// saturate, then apply the selected activation.
module tdnn_act_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [1:0]            act_mode_i,
    output logic signed [DATA_WIDTH-1:0] res_o
);
    import tdnn_pkg::*;

    logic signed [63:0] acc_ext;
    logic signed [63:0] rnd;
    logic signed [15:0] sat;
    logic signed [15:0] act;

    always_comb begin
        acc_ext = {{(64-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
        rnd     = (acc_ext + ROUND_CONST) >>> FRAC_BITS;
        sat     = sat16(rnd);
        act     = sat;
        case (act_mode_i)
            ACT_LEAKY: if (sat[15]) act = sat >>> 3;
            ACT_RELU:  if (sat[15]) act = '0;
            default:   act = sat;
        endcase
        res_o = DATA_WIDTH'(act);
    end

endmodule

// File: rtl/tdnn_fc_engine.sv
// Time-multiplexed fully-connected layer: one MAC streams IN_DIM weights plus
// a bias per neuron from banked synchronous RAM and emits OUT_DIM results.
module tdnn_fc_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int IN_DIM      = 22,
    parameter int OUT_DIM     = 32,
    parameter int ACC_WIDTH   = 40,
    parameter int WADDR_WIDTH = 16,
    parameter int N_BANKS     = 3,
    parameter int BANK_STRIDE = 1298,
    parameter int LAYER_BASE  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH*IN_DIM-1:0]   in_vector,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     bank_sel,
    input  logic [1:0]                     act_mode,
    output logic [WADDR_WIDTH-1:0]         weight_addr,
    input  logic [DATA_WIDTH-1:0]          weight_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(OUT_DIM)-1:0]     out_idx,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           bank_err
);
    import tdnn_pkg::*;

    localparam int CNT_W = $clog2(IN_DIM + 1);
    localparam int IDX_W = $clog2(OUT_DIM);

    state_t state_q, state_d;

    logic                          accept, fetch_start, last_nrn, bad_bank;
    logic [IDX_W-1:0]              fetch_nidx;
    logic [CNT_W-1:0]              cnt_nxt;
    logic [DATA_WIDTH*IN_DIM-1:0]  vec_q;
    logic [1:0]                    bank_q, mode_q;
    logic                          bank_err_q;
    logic [IDX_W-1:0]              nidx_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [WADDR_WIDTH-1:0]        addr_q;
    logic                          addr_vld_q, addr_bias_q, rd_vld_q, rd_bias_q, prod_vld_q;
    logic [CNT_W-1:0]              addr_i_q, rd_i_q;
    logic signed [DATA_WIDTH-1:0]  x_sel, w_s, act_res;
    logic signed [2*DATA_WIDTH-1:0] x_ext, w_ext, mul;
    logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, prod_q, acc_q;
    logic [DATA_WIDTH-1:0]         out_data_q;
    logic [IDX_W-1:0]              out_idx_q;
    logic                          out_last_q;

    function automatic logic [WADDR_WIDTH-1:0] waddr(input logic [1:0] bank,
                                                     input logic [IDX_W-1:0] nrn,
                                                     input int i,
                                                     input logic is_bias);
        int a;
        a = LAYER_BASE + int'(bank) * BANK_STRIDE;
        if (is_bias)
            a = a + OUT_DIM * IN_DIM + int'(nrn);
        else
            a = a + int'(nrn) * IN_DIM + i;
        return WADDR_WIDTH'(a);
    endfunction

    assign last_nrn = (nidx_q == IDX_W'(OUT_DIM - 1));
    assign cnt_nxt  = cnt_q + CNT_W'(1);
    assign bad_bank = (int'(bank_sel) >= N_BANKS);

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        fetch_start = 1'b0;
        fetch_nidx  = nidx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d     = ST_FETCH;
                fetch_start = 1'b1;
                fetch_nidx  = '0;
            end
            ST_FETCH: if (cnt_q == CNT_W'(IN_DIM)) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == CNT_W'(2)) state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (last_nrn) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_FETCH;
                        fetch_start = 1'b1;
                        fetch_nidx  = nidx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control: sequencing, address generation and valid tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= '0;
            mode_q      <= '0;
            bank_err_q  <= 1'b0;
            nidx_q      <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            addr_vld_q  <= 1'b0;
            addr_bias_q <= 1'b0;
            addr_i_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_bias_q   <= 1'b0;
            rd_i_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_vld_q   <= addr_vld_q;
            rd_bias_q  <= addr_bias_q;
            rd_i_q     <= addr_i_q;
            prod_vld_q <= rd_vld_q;
            if (accept) begin
                bank_q <= bad_bank ? 2'd0 : bank_sel;
                mode_q <= act_mode;
                if (bad_bank) bank_err_q <= 1'b1;
            end
            if (fetch_start) begin
                nidx_q      <= fetch_nidx;
                cnt_q       <= '0;
                addr_q      <= waddr(bank_q, fetch_nidx, 0, 1'b0);
                addr_vld_q  <= 1'b1;
                addr_bias_q <= 1'b0;
                addr_i_q    <= '0;
            end else if (state_q == ST_FETCH) begin
                if (cnt_q == CNT_W'(IN_DIM)) begin
                    cnt_q      <= '0;
                    addr_vld_q <= 1'b0;
                end else begin
                    cnt_q       <= cnt_nxt;
                    addr_q      <= waddr(bank_q, nidx_q, int'(cnt_nxt), cnt_nxt == CNT_W'(IN_DIM));
                    addr_bias_q <= (cnt_nxt == CNT_W'(IN_DIM));
                    addr_i_q    <= cnt_nxt;
                end
            end else if (state_q == ST_DRAIN) begin
                cnt_q <= cnt_nxt;
                if (cnt_q == CNT_W'(2)) begin
                    cnt_q      <= '0;
                    out_data_q <= act_res;
                    out_idx_q  <= nidx_q;
                    out_last_q <= last_nrn;
                end
            end
        end
    end

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < IN_DIM; i++)
            if (rd_i_q == CNT_W'(i)) x_sel = vec_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_s      = weight_data;
    assign x_ext    = {{DATA_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
    assign w_ext    = {{DATA_WIDTH{w_s[DATA_WIDTH-1]}}, w_s};
    assign mul      = x_ext * w_ext;
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){mul[2*DATA_WIDTH-1]}}, mul};
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){w_s[DATA_WIDTH-1]}}, w_s, {FRAC_BITS{1'b0}}};

    // Datapath: product register then accumulate; cleared on each neuron start
    always_ff @(posedge clk) begin
        if (accept) vec_q <= in_vector;
        if (rd_vld_q) prod_q <= rd_bias_q ? bias_ext : prod_ext;
        if (fetch_start)
            acc_q <= '0;
        else if (prod_vld_q)
            acc_q <= acc_q + prod_q;
    end

    tdnn_act_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_act (
        .acc_i      (acc_q),
        .act_mode_i (mode_q),
        .res_o      (act_res)
    );

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;
    assign weight_addr = addr_q;
    assign bank_err    = bank_err_q;

endmodule
